aes_gcm_hj0_engine: RTL and testbench

Parametrised AES-GCM pre-processing stage: derives the hash subkey H = AES_K(0^128) and the pre-counter block J0 = IV||0^31||1 for each new instance. It sits between key expansion and the GHASH/CTR stages. It computes H iteratively, one AES round per cycle, and supports 128- and 256-bit keys. Between instances it caches H and J0, and adds a valid/ready handshake on both sides.

---
 rtl/aes_gcm_pkg.sv | 38 +++
 rtl/aes_round.sv | 37 +++
 rtl/aes_gcm_hj0_engine.sv | 187 ++++++++++++++++++
 tb/tb_aes_gcm_hj0_engine.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_gcm_pkg.sv
// rtl/aes_gcm_pkg.sv - shared AES-GCM types and helper functions (S-box, xtime, inc32, sizing)
package aes_gcm_pkg;

    typedef logic [0:127] block_t;

    // Forward S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] inc32(input logic [127:0] b);
        return {b[127:32], b[31:0] + 32'd1};
    endfunction

    function automatic int nr_of(input int key_bits);
        return (key_bits == 256) ? 14 : 10;
    endfunction

    function automatic int ks_w_of(input int key_bits);
        return 128 * (nr_of(key_bits) + 1);
    endfunction

endpackage

// File: rtl/aes_round.sv
// rtl/aes_round.sv - one combinational AES encryption round
module aes_round
    import aes_gcm_pkg::*;
(
    input  block_t i_state,
    input  block_t i_rk,
    input  logic   i_last,
    output block_t o_state
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    // Byte n of the block sits at row n%4, column n/4.
    always_comb begin
        o_state = '0;
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(i_state[8*i +: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c + r] = sb[4*((c + r) % 4) + r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c]     = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c + 1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c + 2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c + 3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        for (int i = 0; i < 16; i++) begin
            o_state[8*i +: 8] = (i_last ? sr[i] : mc[i]) ^ i_rk[8*i +: 8];
        end
    end

endmodule

// File: rtl/aes_gcm_hj0_engine.sv
// rtl/aes_gcm_hj0_engine.sv - GCM H/J0 derivation stage; AES_HJ0_CTR1_EN adds the o_ctr1 output
module aes_gcm_hj0_engine
    import aes_gcm_pkg::*;
#(
    parameter  int KEY_BITS = 128,
    localparam int NR       = nr_of(KEY_BITS),
    localparam int KS_W     = ks_w_of(KEY_BITS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_new_instance,
    input  logic            i_pt_instance,
    input  logic [127:0]    i_plain_text,
    input  logic [127:0]    i_aad,
    input  logic [127:0]    i_instance_size,
    input  logic [95:0]     i_iv,
    input  logic [KS_W-1:0] i_key_schedule,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [127:0]    o_h,
    output logic [127:0]    o_j0,
`ifdef AES_HJ0_CTR1_EN
    output logic [127:0]    o_ctr1,
`endif
    output logic [KS_W-1:0] o_key_schedule,
    output logic [127:0]    o_plain_text,
    output logic [127:0]    o_aad,
    output logic [127:0]    o_instance_size,
    output logic            o_new_instance,
    output logic            o_pt_instance,
    output logic            o_busy
);

    typedef enum logic [1:0] {IDLE, ROUND, HOLD} state_e;

    localparam logic [3:0] RND_LAST = 4'(NR);
    localparam logic [3:0] RND_DONE = 4'(NR + 1);

    state_e          state_q, state_d;
    logic [3:0]      rnd_q, rnd_d;
    block_t          blk_q, blk_d;
    logic [127:0]    h_q, h_d, j0_q, j0_d;
    logic [95:0]     iv_q, iv_d;
    logic [KS_W-1:0] ks_q, ks_d;
    logic [127:0]    pt_q, pt_d, aad_q, aad_d, size_q, size_d;
    logic            new_q, new_d, pti_q, pti_d, valid_q, valid_d;
    logic [KS_W-1:0] ks_sh;
    block_t          round_out;
    logic            accept;

    // Shifting by rnd*128 brings rk[rnd] to the top; past the last key it reads zero.
    assign ks_sh = ks_q << {rnd_q, 7'b0};

    aes_round u_round (
        .i_state (blk_q),
        .i_rk    (ks_sh[KS_W-1 -: 128]),
        .i_last  (rnd_q == RND_LAST),
        .o_state (round_out)
    );

    assign o_ready = (state_q == IDLE) && (!valid_q || i_ready);
    assign accept  = i_valid && o_ready;

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        blk_d   = blk_q;
        h_d     = h_q;
        j0_d    = j0_q;
        iv_d    = iv_q;
        ks_d    = ks_q;
        pt_d    = pt_q;
        aad_d   = aad_q;
        size_d  = size_q;
        new_d   = new_q;
        pti_d   = pti_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    pt_d   = i_plain_text;
                    aad_d  = i_aad;
                    size_d = i_instance_size;
                    new_d  = i_new_instance;
                    pti_d  = i_pt_instance;
                    if (i_new_instance) begin
                        ks_d    = i_key_schedule;
                        iv_d    = i_iv;
                        blk_d   = i_key_schedule[KS_W-1 -: 128];
                        rnd_d   = 4'd1;
                        valid_d = 1'b0;
                        state_d = ROUND;
                    end else begin
                        valid_d = 1'b1;
                    end
                end else if (i_ready) begin
                    valid_d = 1'b0;
                end
            end
            ROUND: begin
                if (rnd_q == RND_DONE) begin
                    h_d     = blk_q;
                    j0_d    = {iv_q, 32'h1};
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    blk_d = round_out;
                    rnd_d = rnd_q + 4'd1;
                end
            end
            HOLD: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            blk_q   <= '0;
            h_q     <= '0;
            j0_q    <= '0;
            iv_q    <= '0;
            ks_q    <= '0;
            pt_q    <= '0;
            aad_q   <= '0;
            size_q  <= '0;
            new_q   <= 1'b0;
            pti_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            blk_q   <= blk_d;
            h_q     <= h_d;
            j0_q    <= j0_d;
            iv_q    <= iv_d;
            ks_q    <= ks_d;
            pt_q    <= pt_d;
            aad_q   <= aad_d;
            size_q  <= size_d;
            new_q   <= new_d;
            pti_q   <= pti_d;
            valid_q <= valid_d;
        end
    end

`ifdef AES_HJ0_CTR1_EN
    logic [127:0] ctr1_q, ctr1_d;

    always_comb begin
        ctr1_d = ctr1_q;
        if (state_q == ROUND && rnd_q == RND_DONE) begin
            ctr1_d = inc32({iv_q, 32'h1});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr1_q <= '0;
        end else begin
            ctr1_q <= ctr1_d;
        end
    end

    assign o_ctr1 = ctr1_q;
`endif

    assign o_valid         = valid_q;
    assign o_h             = h_q;
    assign o_j0            = j0_q;
    assign o_key_schedule  = ks_q;
    assign o_plain_text    = pt_q;
    assign o_aad           = aad_q;
    assign o_instance_size = size_q;
    assign o_new_instance  = new_q;
    assign o_pt_instance   = pti_q;
    assign o_busy          = (state_q == ROUND);

endmodule

// File: tb/tb_aes_gcm_hj0_engine.sv
// tb/tb_aes_gcm_hj0_engine.sv - directed self-checking bench for aes_gcm_hj0_engine (AES-128 and AES-256)
module tb_aes_gcm_hj0_engine;
    import aes_gcm_pkg::*;

    localparam int KS128 = 1408;
    localparam int KS256 = 1920;
    localparam logic [127:0] H128  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] H256  = 128'hdc95c078a2408989ad48a21492842087;
    localparam logic [95:0]  IV    = 96'hcafebabefacedbaddecaf888;
    localparam logic [127:0] J0    = 128'hcafebabefacedbaddecaf88800000001;
    localparam logic [127:0] RK1   = 128'h62636363626363636263636362636363;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             i_valid = 1'b0, i_new = 1'b0, i_pti = 1'b0, i_ready = 1'b1;
    logic [127:0]     i_pt = '0, i_aad = '0, i_size = '0;
    logic [95:0]      i_iv = '0;
    logic [KS128-1:0] i_ks = '0;
    logic             o_ready, o_valid, o_new, o_pti, o_busy;
    logic [127:0]     o_h, o_j0, o_pt, o_aad, o_size, o_ctr1;
    logic [KS128-1:0] o_ks;

    logic             v2 = 1'b0, n2 = 1'b0, r2 = 1'b1;
    logic [KS256-1:0] ks2 = '0;
    logic             o_ready2, o_valid2, o_new2, o_pti2, o_busy2;
    logic [127:0]     o_h2, o_j02, o_pt2, o_aad2, o_size2, o_ctr12;
    logic [KS256-1:0] o_ks2;

    aes_gcm_hj0_engine #(.KEY_BITS(128)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_new_instance(i_new), .i_pt_instance(i_pti), .i_plain_text(i_pt),
        .i_aad(i_aad), .i_instance_size(i_size), .i_iv(i_iv), .i_key_schedule(i_ks),
        .o_valid(o_valid), .i_ready(i_ready), .o_h(o_h), .o_j0(o_j0),
`ifdef AES_HJ0_CTR1_EN
        .o_ctr1(o_ctr1),
`endif
        .o_key_schedule(o_ks), .o_plain_text(o_pt), .o_aad(o_aad),
        .o_instance_size(o_size), .o_new_instance(o_new), .o_pt_instance(o_pti),
        .o_busy(o_busy)
    );

    aes_gcm_hj0_engine #(.KEY_BITS(256)) dut256 (
        .clk(clk), .rst(rst), .i_valid(v2), .o_ready(o_ready2),
        .i_new_instance(n2), .i_pt_instance(i_pti), .i_plain_text(i_pt),
        .i_aad(i_aad), .i_instance_size(i_size), .i_iv(i_iv), .i_key_schedule(ks2),
        .o_valid(o_valid2), .i_ready(r2), .o_h(o_h2), .o_j0(o_j02),
`ifdef AES_HJ0_CTR1_EN
        .o_ctr1(o_ctr12),
`endif
        .o_key_schedule(o_ks2), .o_plain_text(o_pt2), .o_aad(o_aad2),
        .o_instance_size(o_size2), .o_new_instance(o_new2), .o_pt_instance(o_pti2),
        .o_busy(o_busy2)
    );

`ifndef AES_HJ0_CTR1_EN
    assign o_ctr1  = '0;
    assign o_ctr12 = '0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Standard FIPS-197 key expansion of an all-zero key; rk0 lands in the top 128 bits.
    function automatic logic [1919:0] zero_ks(input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] ks;
        int            nr;
        nr = nk + 6;
        rc = 8'h01;
        ks = '0;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < 4 * (nr + 1); i++) ks[1919 - 32*i -: 32] = w[i];
        return ks;
    endfunction

    logic [1919:0] full128, full256;
    logic [127:0]  h_hold, pt_exp;
    int            cnt;

    initial begin
        full128 = zero_ks(4);
        full256 = zero_ks(8);

        step(); step();
        check("rst_valid", {127'd0, o_valid}, 128'd0);
        check("rst_h", o_h, 128'd0);
        check("rst_j0", o_j0, 128'd0);
        check("rst_busy", {127'd0, o_busy}, 128'd0);
        rst = 1'b0;
        step();
        check("rst_ready", {127'd0, o_ready}, 128'd1);

        // Non-new beat before any instance: zero caches.
        i_valid = 1'b1; i_new = 1'b0; i_pti = 1'b1; i_ready = 1'b1;
        i_pt = 128'h0011223344556677_8899aabbccddeeff; i_aad = 128'h5a5a; i_size = 128'h80;
        step();
        i_valid = 1'b0;
        check("pre_valid", {127'd0, o_valid}, 128'd1);
        check("pre_pt", o_pt, 128'h0011223344556677_8899aabbccddeeff);
        check("pre_aad", o_aad, 128'h5a5a);
        check("pre_pti", {127'd0, o_pti}, 128'd1);
        check("pre_h", o_h, 128'd0);
        check("pre_j0", o_j0, 128'd0);
        check("pre_ks", o_ks[127:0], 128'd0);
        step();
        check("pre_drain", {127'd0, o_valid}, 128'd0);

        // AES-128 new instance, downstream stalled through HOLD.
        i_valid = 1'b1; i_new = 1'b1; i_pti = 1'b0; i_ready = 1'b0;
        i_iv = IV; i_ks = full128[1919 -: KS128]; i_pt = 128'h1111;
        step();
        i_valid = 1'b0; i_new = 1'b0;
        check("new_busy", {127'd0, o_busy}, 128'd1);
        check("new_ready_low", {127'd0, o_ready}, 128'd0);
        cnt = 0;
        while (!o_valid && cnt < 40) begin
            step();
            cnt++;
        end
        check("lat128", 128'(cnt), 128'd11);
        check("h128", o_h, H128);
        check("j0_128", o_j0, J0);
`ifdef AES_HJ0_CTR1_EN
        check("ctr1_128", o_ctr1, 128'hcafebabefacedbaddecaf88800000002);
`endif
        check("new_flag", {127'd0, o_new}, 128'd1);
        check("new_pt", o_pt, 128'h1111);
        check("ks_rk1", o_ks[KS128-129 -: 128], RK1);
        check("ks_rk10", o_ks[127:0], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        for (int k = 0; k < 5; k++) begin
            step();
            check("hold_valid", {127'd0, o_valid}, 128'd1);
            check("hold_ready", {127'd0, o_ready}, 128'd0);
            check("hold_h", o_h, H128);
        end
        i_ready = 1'b1;
        step();
        check("hold_release", {127'd0, o_valid}, 128'd0);
        check("idle_ready", {127'd0, o_ready}, 128'd1);

        // Four back-to-back non-new beats.
        for (int k = 0; k < 4; k++) begin
            i_valid = 1'b1; i_new = 1'b0;
            pt_exp  = 128'hbeef0000 + 128'(k);
            i_pt    = pt_exp;
            step();
            check("b2b_valid", {127'd0, o_valid}, 128'd1);
            check("b2b_pt", o_pt, pt_exp);
            check("b2b_h", o_h, H128);
            check("b2b_j0", o_j0, J0);
            check("b2b_ready", {127'd0, o_ready}, 128'd1);
        end
        i_valid = 1'b0;
        step();
        check("b2b_drain", {127'd0, o_valid}, 128'd0);

        // Reset in the middle of the rounds, then recompute.
        i_valid = 1'b1; i_new = 1'b1; i_iv = 96'h1; i_pt = 128'h2222;
        step();
        i_valid = 1'b0; i_new = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("mid_busy", {127'd0, o_busy}, 128'd1);
        rst = 1'b1;
        step();
        check("mrst_valid", {127'd0, o_valid}, 128'd0);
        check("mrst_busy", {127'd0, o_busy}, 128'd0);
        check("mrst_ready", {127'd0, o_ready}, 128'd1);
        check("mrst_h", o_h, 128'd0);
        check("mrst_j0", o_j0, 128'd0);
        check("mrst_pt", o_pt, 128'd0);
        check("mrst_ks", o_ks[127:0], 128'd0);
        rst = 1'b0;
        step();
        i_valid = 1'b1; i_new = 1'b1; i_iv = IV;
        step();
        i_valid = 1'b0; i_new = 1'b0;
        cnt = 0;
        while (!o_valid && cnt < 40) begin
            step();
            cnt++;
        end
        check("lat_again", 128'(cnt), 128'd11);
        check("h_again", o_h, H128);
        check("j0_again", o_j0, J0);
        step();

        // AES-256 instance.
        v2 = 1'b1; n2 = 1'b1; ks2 = full256;
        step();
        v2 = 1'b0; n2 = 1'b0;
        cnt = 0;
        while (!o_valid2 && cnt < 40) begin
            step();
            cnt++;
        end
        check("lat256", 128'(cnt), 128'd15);
        check("h256", o_h2, H256);
        check("j0_256", o_j02, J0);
`ifdef AES_HJ0_CTR1_EN
        check("ctr1_256", o_ctr12, 128'hcafebabefacedbaddecaf88800000002);
`endif
        step();
        check("drain256", {127'd0, o_valid2}, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
